// File: rtl/float_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : float_normalizer
//  Description : Back end of the FP adder. Normalizes a raw mantissa sum one
//                bit per cycle, tracking the biased exponent, and reports
//                zero / overflow / underflow on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module float_normalizer #(
    parameter int N = 8,   // biased exponent width
    parameter int M = 23   // fraction width, hidden bit excluded
) (
    input  logic         Clock,
    input  logic         ResetN,
    input  logic         InValid,
    output logic         InReady,
    input  logic [N-1:0] ExpIn,
    input  logic [M+1:0] SumIn,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [N-1:0] ExpOut,
    output logic [M-1:0] MantOut,
    output logic         Zero,
    output logic         Overflow,
    output logic         Underflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [N-1:0] c_expOnes = {N{1'b1}};
    localparam logic [N-1:0] c_expMax  = {{(N-1){1'b1}}, 1'b0};  // largest finite exponent
    localparam logic [N-1:0] c_expOne  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] c_expZero = {N{1'b0}};

    stateT        r_state;
    stateT        w_nextState;
    logic [N-1:0] r_exp;
    logic [M+1:0] r_sum;
    logic [N-1:0] w_nextExp;
    logic [M+1:0] w_nextSum;

    logic [N-1:0] r_expOut;
    logic [M-1:0] r_mantOut;
    logic         r_zero;
    logic         r_overflow;
    logic         r_underflow;

    // Result values captured on the transition into DONE
    logic         w_loadOut;
    logic [N-1:0] w_resExp;
    logic [M-1:0] w_resMant;
    logic         w_resZero;
    logic         w_resOverflow;
    logic         w_resUnderflow;

    assign InReady   = (r_state == IDLE) && ResetN;
    assign OutValid  = (r_state == DONE);
    assign ExpOut    = r_expOut;
    assign MantOut   = r_mantOut;
    assign Zero      = r_zero;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;

    // State register; reset drops any operand in flight
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Working exponent/sum and the held result registers
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_exp       <= c_expZero;
            r_sum       <= '0;
            r_expOut    <= c_expZero;
            r_mantOut   <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_exp <= w_nextExp;
            r_sum <= w_nextSum;
            if (w_loadOut) begin
                r_expOut    <= w_resExp;
                r_mantOut   <= w_resMant;
                r_zero      <= w_resZero;
                r_overflow  <= w_resOverflow;
                r_underflow <= w_resUnderflow;
            end
        end
    end

    // Next-state, one normalization step per cycle, and result selection
    always_comb begin
        w_nextState    = r_state;
        w_nextExp      = r_exp;
        w_nextSum      = r_sum;
        w_loadOut      = 1'b0;
        w_resExp       = c_expZero;
        w_resMant      = '0;
        w_resZero      = 1'b0;
        w_resOverflow  = 1'b0;
        w_resUnderflow = 1'b0;

        case (r_state)
            IDLE: begin
                if (InValid) begin
                    w_nextExp = ExpIn;
                    w_nextSum = SumIn;
                    if (SumIn == '0) begin
                        w_nextState = DONE;
                        w_loadOut   = 1'b1;
                        w_resZero   = 1'b1;
                    end else if (ExpIn == c_expOnes) begin
                        w_nextState   = DONE;
                        w_loadOut     = 1'b1;
                        w_resOverflow = 1'b1;
                        w_resExp      = c_expOnes;
                    end else if (ExpIn == c_expZero) begin
                        // Denormal inputs are flushed rather than normalized
                        w_nextState    = DONE;
                        w_loadOut      = 1'b1;
                        w_resUnderflow = 1'b1;
                    end else begin
                        w_nextState = NORM;
                    end
                end
            end

            NORM: begin
                if (r_sum[M+1] && (r_exp == c_expMax)) begin
                    w_nextState   = DONE;
                    w_loadOut     = 1'b1;
                    w_resOverflow = 1'b1;
                    w_resExp      = c_expOnes;
                end else if (r_sum[M+1]) begin
                    // Carry out: shift right, truncating the LSB
                    w_nextSum = r_sum >> 1;
                    w_nextExp = r_exp + c_expOne;
                end else if (!r_sum[M] && (r_exp == c_expOne)) begin
                    w_nextState    = DONE;
                    w_loadOut      = 1'b1;
                    w_resUnderflow = 1'b1;
                end else if (!r_sum[M]) begin
                    w_nextSum = r_sum << 1;
                    w_nextExp = r_exp - c_expOne;
                end else begin
                    w_nextState = DONE;
                    w_loadOut   = 1'b1;
                    w_resExp    = r_exp;
                    w_resMant   = r_sum[M-1:0];
                end
            end

            DONE: begin
                if (OutReady) begin
                    w_nextState = IDLE;
                end
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_float_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_float_normalizer
//  Description : Directed-vector bench for float_normalizer. The driver pushes
//                expected results into a queue; a monitor pops and compares
//                on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_float_normalizer;

    localparam int N = 8;
    localparam int M = 23;

    logic         Clock = 1'b0;
    logic         ResetN = 1'b0;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [N-1:0] ExpIn = '0;
    logic [M+1:0] SumIn = '0;
    logic         OutValid;
    logic         OutReady = 1'b1;
    logic [N-1:0] ExpOut;
    logic [M-1:0] MantOut;
    logic         Zero;
    logic         Overflow;
    logic         Underflow;

    float_normalizer #(.N(N), .M(M)) dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .InValid  (InValid),
        .InReady  (InReady),
        .ExpIn    (ExpIn),
        .SumIn    (SumIn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .ExpOut   (ExpOut),
        .MantOut  (MantOut),
        .Zero     (Zero),
        .Overflow (Overflow),
        .Underflow(Underflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [N-1:0] e;
        logic [M-1:0] m;
        logic         z;
        logic         o;
        logic         u;
        int           lat;
        int           acc;
        string        name;
    } expT;

    expT sb[$];

    int passCnt  = 0;
    int checkCnt = 0;
    int cycleCnt = 0;

    always @(posedge Clock) cycleCnt <= cycleCnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCnt++;
        if (act === req) passCnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: compare on handshake, verify stability while stalled
    logic         inResult = 1'b0;
    int           firstCycle = 0;
    logic [N-1:0] snapExp;
    logic [M-1:0] snapMant;
    logic [2:0]   snapFlags;

    always @(negedge Clock) begin
        if (!ResetN) begin
            inResult = 1'b0;
        end else if (OutValid) begin
            if (!inResult) begin
                inResult   = 1'b1;
                firstCycle = cycleCnt;
                snapExp    = ExpOut;
                snapMant   = MantOut;
                snapFlags  = {Zero, Overflow, Underflow};
            end else begin
                check("hold_exp", 32'(ExpOut), 32'(snapExp));
                check("hold_mant", 32'(MantOut), 32'(snapMant));
                check("hold_flags", 32'({Zero, Overflow, Underflow}), 32'(snapFlags));
                check("hold_inready", 32'(InReady), 32'd0);
            end
            if (OutReady) begin
                if (sb.size() == 0) begin
                    check("spurious_output", 32'(sb.size()), 32'd1);
                end else begin
                    expT x;
                    x = sb.pop_front();
                    check({x.name, "_exp"}, 32'(ExpOut), 32'(x.e));
                    check({x.name, "_mant"}, 32'(MantOut), 32'(x.m));
                    check({x.name, "_flags"}, 32'({Zero, Overflow, Underflow}),
                          32'({x.z, x.o, x.u}));
                    check({x.name, "_latency"}, 32'(firstCycle - x.acc + 1), 32'(x.lat));
                end
                inResult = 1'b0;
            end
        end
    end

    // Drive one operand, optionally stall the output for bp cycles, wait for completion
    task automatic issue(input string name, input logic [N-1:0] e, input logic [M+1:0] s,
                         input logic [N-1:0] ee, input logic [M-1:0] em,
                         input logic z, input logic o, input logic u,
                         input int lat, input int bp);
        bit got = 0;
        bit seen = 0;
        @(posedge Clock); #1;
        OutReady = (bp == 0);
        InValid  = 1'b1;
        ExpIn    = e;
        SumIn    = s;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clock);
            if (InReady) begin
                expT x;
                x.e = ee; x.m = em; x.z = z; x.o = o; x.u = u;
                x.lat = lat; x.acc = cycleCnt + 1; x.name = name;
                sb.push_back(x);
                got = 1;
            end
        end
        @(posedge Clock); #1;
        InValid = 1'b0;
        if (!got) begin
            check({name, "_accept_timeout"}, 32'(got), 32'd1);
            return;
        end
        if (bp > 0) begin
            for (int i = 0; i < 60 && !seen; i++) begin
                @(negedge Clock);
                if (OutValid) seen = 1;
            end
            if (!seen) check({name, "_valid_timeout"}, 32'(seen), 32'd1);
            @(posedge Clock); #1;
            // Offer a junk operand while busy; it must be ignored
            InValid = 1'b1;
            ExpIn   = 8'h33;
            SumIn   = 25'h0123456;
            repeat (bp) @(negedge Clock);
            @(posedge Clock); #1;
            InValid  = 1'b0;
            OutReady = 1'b1;
        end
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge Clock);
        if (sb.size() != 0) begin
            check({name, "_result_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("reset_outvalid", 32'(OutValid), 32'd0);
        check("reset_exp", 32'(ExpOut), 32'd0);
        check("reset_mant", 32'(MantOut), 32'd0);
        check("reset_flags", 32'({Zero, Overflow, Underflow}), 32'd0);
        check("reset_inready_low", 32'(InReady), 32'd0);
        @(posedge Clock); #1;
        ResetN = 1'b1;
        @(negedge Clock);
        check("reset_inready_high", 32'(InReady), 32'd1);

        //     name        ExpIn  SumIn         ExpOut MantOut      Z     O     U    lat bp
        issue("carry",     8'h80, 25'h1800000, 8'h81, 23'h400000, 1'b0, 1'b0, 1'b0, 3, 0);
        issue("lshift",    8'h7F, 25'h0100000, 8'h7C, 23'h000000, 1'b0, 1'b0, 1'b0, 5, 0);
        issue("zero",      8'h90, 25'h0000000, 8'h00, 23'h000000, 1'b1, 1'b0, 1'b0, 1, 0);
        issue("ovf_norm",  8'hFE, 25'h1000000, 8'hFF, 23'h000000, 1'b0, 1'b1, 1'b0, 2, 0);
        issue("unf_norm",  8'h02, 25'h0000001, 8'h00, 23'h000000, 1'b0, 1'b0, 1'b1, 3, 0);
        issue("ovf_idle",  8'hFF, 25'h0800000, 8'hFF, 23'h000000, 1'b0, 1'b1, 1'b0, 1, 0);
        issue("unf_idle",  8'h00, 25'h0800000, 8'h00, 23'h000000, 1'b0, 1'b0, 1'b1, 1, 0);
        issue("normal",    8'h85, 25'h0ABCDEF, 8'h85, 23'h2BCDEF, 1'b0, 1'b0, 1'b0, 2, 0);
        issue("truncate",  8'h40, 25'h1FFFFFF, 8'h41, 23'h7FFFFF, 1'b0, 1'b0, 1'b0, 3, 0);
        issue("zero_ff",   8'hFF, 25'h0000000, 8'h00, 23'h000000, 1'b1, 1'b0, 1'b0, 1, 0);
        issue("carry_fd",  8'hFD, 25'h1000000, 8'hFE, 23'h000000, 1'b0, 1'b0, 1'b0, 3, 0);
        issue("unf_exp1",  8'h01, 25'h0400000, 8'h00, 23'h000000, 1'b0, 1'b0, 1'b1, 2, 0);
        issue("worst",     8'h80, 25'h0000001, 8'h69, 23'h000000, 1'b0, 1'b0, 1'b0, 25, 0);
        issue("bp_carry",  8'h80, 25'h1800000, 8'h81, 23'h400000, 1'b0, 1'b0, 1'b0, 3, 4);
        issue("bp_zero",   8'h10, 25'h0000000, 8'h00, 23'h000000, 1'b1, 1'b0, 1'b0, 1, 4);

        // Reset in the middle of a long normalization
        @(posedge Clock); #1;
        InValid = 1'b1;
        ExpIn   = 8'h80;
        SumIn   = 25'h0000001;
        @(posedge Clock); #1;
        InValid = 1'b0;
        repeat (5) @(posedge Clock);
        #1;
        ResetN = 1'b0;
        @(negedge Clock);
        check("midreset_outvalid", 32'(OutValid), 32'd0);
        check("midreset_exp", 32'(ExpOut), 32'd0);
        check("midreset_mant", 32'(MantOut), 32'd0);
        check("midreset_inready", 32'(InReady), 32'd0);
        @(posedge Clock); #1;
        ResetN = 1'b1;
        @(negedge Clock);
        check("postreset_inready", 32'(InReady), 32'd1);
        check("postreset_outvalid", 32'(OutValid), 32'd0);
        repeat (30) @(negedge Clock);
        check("postreset_no_output", 32'(OutValid), 32'd0);

        issue("recover",   8'h7F, 25'h0100000, 8'h7C, 23'h000000, 1'b0, 1'b0, 1'b0, 5, 0);

        repeat (3) @(posedge Clock);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
`default_nettype wire
